// File: rtl/if_fetch_unit_pkg.sv
// Shared types and defaults for the instruction-fetch stage (package if_pkg).
package if_pkg;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_INST_W = 32;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] pc;
    logic [DEF_INST_W-1:0] inst;
  } fq_entry_t;
endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory and decode-side bus of the fetch stage.
// Handshakes: a request transfers when imem_req && imem_gnt; a response is an unconditional
// one-cycle imem_rvalid strobe; the decode entry transfers when id_valid && !load_use_hazard.
interface if_fetch_unit_if #(
  parameter int ADDR_W = 16,
  parameter int INST_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [INST_W-1:0] imem_rdata;
  logic              id_valid;
  logic [ADDR_W-1:0] id_pc;
  logic [INST_W-1:0] id_inst;
  logic              load_use_hazard;

  modport master (
    output imem_req, imem_addr, id_valid, id_pc, id_inst,
    input  imem_gnt, imem_rvalid, imem_rdata, load_use_hazard
  );

  modport slave (
    input  imem_req, imem_addr, id_valid, id_pc, id_inst,
    output imem_gnt, imem_rvalid, imem_rdata, load_use_hazard
  );
endinterface

// File: rtl/if_fetch_queue.sv
// Synchronous FIFO with clear; DEPTH need not be a power of two. Read data is the registered head.
module if_fetch_queue
  import if_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = fq_entry_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clear,
  input  entry_t                 din,
  output entry_t                 dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full queue is only taken when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && rst && !clear) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: credit-based imem requests, in-order response queue, flush squashing.
// Optional IF_PERF_CNT_EN adds saturating stall / flush performance counters.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int INST_W    = DEF_INST_W,
  parameter int FQ_DEPTH  = 2,
  parameter int MAX_OUTST = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              pc_en,
  input  logic              flush,
  if_fetch_unit_if.master   bus
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]       perf_stall_cyc,
  output logic [15:0]       perf_flush_cnt
`endif
);
  localparam int FQ_CW = $clog2(FQ_DEPTH) + 1;
  localparam int OS_CW = $clog2(MAX_OUTST) + 1;
  localparam int SUM_W = ((FQ_CW > OS_CW) ? FQ_CW : OS_CW) + 1;
  localparam int SQ_W  = 8;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  entry_t            fq_din;
  entry_t            fq_head;
  entry_t            os_din;
  entry_t            os_head;
  logic [FQ_CW-1:0]  fq_count;
  logic [OS_CW-1:0]  os_count;
  logic              fq_full;
  logic              fq_empty;
  logic              os_full;
  logic              os_empty;
  logic [SUM_W-1:0]  in_use;
  logic              has_credit;
  logic              os_room;
  logic              resp_take;
  logic              id_pop;
  logic [SQ_W-1:0]   squash;
  logic              squash_hit;
  logic              unused_os_inst;

  // Credits count queue slots plus in-flight requests, so every response always has a slot.
  assign in_use     = SUM_W'(fq_count) + SUM_W'(os_count);
  assign has_credit = in_use < SUM_W'(FQ_DEPTH);
  assign os_room    = os_count < OS_CW'(MAX_OUTST);

  assign bus.imem_req  = has_credit && os_room && !flush && rst;
  assign bus.imem_addr = pc_in;
  assign pc_en         = bus.imem_req && bus.imem_gnt;

  assign squash_hit = bus.imem_rvalid && (squash != '0);
  assign resp_take  = bus.imem_rvalid && rst && !flush && (squash == '0) && !os_empty;
  assign id_pop     = bus.id_valid && !bus.load_use_hazard;

  assign os_din  = '{pc: pc_in, inst: '0};
  assign fq_din  = '{pc: os_head.pc, inst: bus.imem_rdata};
  assign unused_os_inst = ^os_head.inst;

  if_fetch_queue #(.DEPTH(MAX_OUTST), .entry_t(entry_t)) u_os_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (pc_en),
    .pop   (resp_take),
    .clear (flush),
    .din   (os_din),
    .dout  (os_head),
    .full  (os_full),
    .empty (os_empty),
    .count (os_count)
  );

  if_fetch_queue #(.DEPTH(FQ_DEPTH), .entry_t(entry_t)) u_dec_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (resp_take),
    .pop   (id_pop),
    .clear (flush),
    .din   (fq_din),
    .dout  (fq_head),
    .full  (fq_full),
    .empty (fq_empty),
    .count (fq_count)
  );

  assign bus.id_valid = !fq_empty;
  assign bus.id_pc    = bus.id_valid ? fq_head.pc   : '0;
  assign bus.id_inst  = bus.id_valid ? fq_head.inst : '0;

  // On flush every in-flight request becomes a response to drop; a response arriving in the
  // flush cycle itself is already consumed, unless it is a protocol-error stray.
  always_ff @(posedge clk) begin
    if (!rst) begin
      squash <= '0;
    end else if (flush) begin
      squash <= squash + SQ_W'(os_count)
              - SQ_W'(bus.imem_rvalid && (squash != '0 || os_count != '0));
    end else if (squash_hit) begin
      squash <= squash - SQ_W'(1);
    end
  end

  a_no_stray_rvalid : assert property (@(posedge clk) disable iff (!rst)
    bus.imem_rvalid |-> (os_count != '0 || squash != '0));

`ifdef IF_PERF_CNT_EN
  logic stall_evt;
  assign stall_evt = (bus.imem_req && !bus.imem_gnt) || !has_credit;

  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_stall_cyc <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (stall_evt && (perf_stall_cyc != '1)) perf_stall_cyc <= perf_stall_cyc + 32'd1;
      if (flush && (perf_flush_cnt != '1))     perf_flush_cnt <= perf_flush_cnt + 16'd1;
    end
  end
`endif
endmodule
